fadd_axis: RTL and testbench

//  Native single-precision FP adder with the AXI4-Stream slave/master interface the FPU

---
 rtl/fadd_axis.sv | 165 ++++++++++++++++
 tb/tb_fadd_axis.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_axis.sv
// fadd_axis: 3-stage pipelined binary32 adder behind AXI4-Stream operand/result channels.
// Optional FADD_AXIS_SUB_EN adds s_axis_a_tuser (1 = compute A-B).
module fadd_axis #(
  parameter logic [31:0] NAN_VALUE = 32'h7FC0_0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_a_tvalid,
  output logic        s_axis_a_tready,
  input  logic [31:0] s_axis_a_tdata,
`ifdef FADD_AXIS_SUB_EN
  input  logic        s_axis_a_tuser,
`endif
  input  logic        s_axis_b_tvalid,
  output logic        s_axis_b_tready,
  input  logic [31:0] s_axis_b_tdata,
  output logic        m_axis_result_tvalid,
  input  logic        m_axis_result_tready,
  output logic [31:0] m_axis_result_tdata
);

  typedef struct packed {
    logic        sign;
    logic        eff_sub;
    logic [7:0]  exp;
    logic [23:0] x_sig;
    logic [26:0] y_al;
    logic        nan;
    logic        inf;
    logic        inf_sign;
  } s1_t;

  typedef struct packed {
    logic        sign;
    logic        zero;
    logic [9:0]  exp;
    logic [26:0] norm;
    logic        nan;
    logic        inf;
    logic        inf_sign;
  } s2_t;

  logic        v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;
  logic        stall1, stall2, stall3, accept, sub_op;
  s1_t         s1_d, s1_q;
  s2_t         s2_d, s2_q;
  logic [31:0] tdata_d, tdata_q;

  logic        a_nan, b_nan, a_inf, b_inf, b_sign, swap;
  logic [30:0] a_mag, b_mag, x_mag, y_mag;
  logic [7:0]  d_exp;
  logic [26:0] y_raw, lost;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic        rnd;
  logic [24:0] mant;
  logic [9:0]  e3;
  logic [22:0] frac;

`ifdef FADD_AXIS_SUB_EN
  assign sub_op = s_axis_a_tuser;
`else
  assign sub_op = 1'b0;
`endif

  // A stage holds only when it is full and everything downstream is blocked.
  assign stall3 = v3_q & ~m_axis_result_tready;
  assign stall2 = v2_q & stall3;
  assign stall1 = v1_q & stall2;
  assign accept = aresetn & s_axis_a_tvalid & s_axis_b_tvalid & ~stall1;
  assign s_axis_a_tready = accept;
  assign s_axis_b_tready = accept;
  assign m_axis_result_tvalid = v3_q;
  assign m_axis_result_tdata  = tdata_q;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  always_comb begin
    v1_d = stall1 ? v1_q : accept;
    v2_d = stall2 ? v2_q : v1_q;
    v3_d = stall3 ? v3_q : v2_q;
  end

  // S1: unpack with flush-to-zero, order by magnitude, align the smaller operand.
  always_comb begin
    b_sign = s_axis_b_tdata[31] ^ sub_op;
    a_nan  = (&s_axis_a_tdata[30:23]) & (|s_axis_a_tdata[22:0]);
    b_nan  = (&s_axis_b_tdata[30:23]) & (|s_axis_b_tdata[22:0]);
    a_inf  = (&s_axis_a_tdata[30:23]) & ~(|s_axis_a_tdata[22:0]);
    b_inf  = (&s_axis_b_tdata[30:23]) & ~(|s_axis_b_tdata[22:0]);
    a_mag  = (s_axis_a_tdata[30:23] == 8'd0) ? 31'd0 : s_axis_a_tdata[30:0];
    b_mag  = (s_axis_b_tdata[30:23] == 8'd0) ? 31'd0 : s_axis_b_tdata[30:0];
    swap   = b_mag > a_mag;
    x_mag  = swap ? b_mag : a_mag;
    y_mag  = swap ? a_mag : b_mag;
    d_exp  = x_mag[30:23] - y_mag[30:23];
    y_raw  = {|y_mag[30:23], y_mag[22:0], 3'b000};
    lost   = y_raw & ~({27{1'b1}} << d_exp);
    s1_d.sign     = swap ? b_sign : s_axis_a_tdata[31];
    s1_d.eff_sub  = s_axis_a_tdata[31] ^ b_sign;
    s1_d.exp      = x_mag[30:23];
    s1_d.x_sig    = {|x_mag[30:23], x_mag[22:0]};
    s1_d.y_al     = (y_raw >> d_exp) | {26'd0, |lost};
    s1_d.nan      = a_nan | b_nan | (a_inf & b_inf & (s_axis_a_tdata[31] ^ b_sign));
    s1_d.inf      = a_inf | b_inf;
    s1_d.inf_sign = a_inf ? s_axis_a_tdata[31] : b_sign;
  end

  // S2: significand add/sub and normalisation; an exact zero is +0 unless both were -0.
  always_comb begin
    sum = s1_q.eff_sub ? {1'b0, s1_q.x_sig, 3'b000} - {1'b0, s1_q.y_al}
                       : {1'b0, s1_q.x_sig, 3'b000} + {1'b0, s1_q.y_al};
    lz  = lzc27(sum[26:0]);
    s2_d.zero = (sum == 28'd0);
    s2_d.sign = s2_d.zero ? (s1_q.sign & ~s1_q.eff_sub) : s1_q.sign;
    if (sum[27]) begin
      s2_d.norm = {sum[27:2], sum[1] | sum[0]};
      s2_d.exp  = {2'b00, s1_q.exp} + 10'd1;
    end else begin
      s2_d.norm = sum[26:0] << lz;
      s2_d.exp  = {2'b00, s1_q.exp} - {5'd0, lz};
    end
    s2_d.nan      = s1_q.nan;
    s2_d.inf      = s1_q.inf;
    s2_d.inf_sign = s1_q.inf_sign;
  end

  // S3: round-to-nearest-even, then specials, overflow and underflow override the packed value.
  always_comb begin
    rnd  = s2_q.norm[2] & (s2_q.norm[3] | s2_q.norm[1] | s2_q.norm[0]);
    mant = {1'b0, s2_q.norm[26:3]} + {24'd0, rnd};
    e3   = s2_q.exp + {9'd0, mant[24]};
    frac = mant[24] ? mant[23:1] : mant[22:0];
    if (s2_q.nan)                                   tdata_d = NAN_VALUE;
    else if (s2_q.inf)                              tdata_d = {s2_q.inf_sign, 8'hFF, 23'd0};
    else if (s2_q.zero || $signed(e3) <= 10'sd0)    tdata_d = {s2_q.sign, 31'd0};
    else if ($signed(e3) >= 10'sd255)               tdata_d = {s2_q.sign, 8'hFF, 23'd0};
    else                                            tdata_d = {s2_q.sign, e3[7:0], frac};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      tdata_q <= 32'd0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      if (!stall1) s1_q <= s1_d;
      if (!stall2) s2_q <= s2_d;
      if (!stall3) tdata_q <= tdata_d;
    end
  end

endmodule

// File: tb/tb_fadd_axis.sv
// tb_fadd_axis: scoreboard bench for fadd_axis; expected sums are hand-derived binary32 constants.
module tb_fadd_axis;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0, m_ready = 1'b1;
  logic        a_ready, b_ready, m_valid;
  logic [31:0] a_data = 32'd0, b_data = 32'd0, m_data;
`ifdef FADD_AXIS_SUB_EN
  logic        a_user = 1'b0;
`endif
  int          n_vec = 0, n_err = 0;
  logic [31:0] sb[$];
  logic        bp_rand = 1'b0;

  localparam int NV = 23;
  localparam logic [95:0] VEC [NV] = '{
    {32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000},
    {32'h7F800000, 32'hFF800000, 32'h7FC00000},
    {32'h7FC00001, 32'h3F800000, 32'h7FC00000},
    {32'h3F800000, 32'hBF800000, 32'h00000000},
    {32'h80000000, 32'h80000000, 32'h80000000},
    {32'h00000001, 32'h00000000, 32'h00000000},
    {32'h4B800000, 32'h3F800000, 32'h4B800000},
    {32'h4B800001, 32'h3F800000, 32'h4B800002},
    {32'h3F800000, 32'hB3800000, 32'h3F7FFFFF},
    {32'h3F800001, 32'h33800000, 32'h3F800002},
    {32'h3F800000, 32'h33800000, 32'h3F800000},
    {32'h00800001, 32'h80800000, 32'h00000000},
    {32'h00400000, 32'h3F800000, 32'h3F800000},
    {32'hFF800000, 32'h7F7FFFFF, 32'hFF800000},
    {32'h3F800000, 32'h7F800000, 32'h7F800000},
    {32'hC0000000, 32'h80000000, 32'hC0000000},
    {32'hBF800000, 32'h3F800000, 32'h00000000},
    {32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000},
    {32'h3F800000, 32'hFFC00000, 32'h7FC00000},
    {32'h7F7FFFFF, 32'h73000000, 32'h7F800000},
    {32'h3FFFFFFF, 32'h33800000, 32'h40000000},
    {32'h3FC00000, 32'h3FC00000, 32'h40400000},
    {32'h3F800000, 32'h40000000, 32'h40400000}
  };

  always #5 aclk = ~aclk;

  fadd_axis dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_a_tvalid      (a_valid),
    .s_axis_a_tready      (a_ready),
    .s_axis_a_tdata       (a_data),
`ifdef FADD_AXIS_SUB_EN
    .s_axis_a_tuser       (a_user),
`endif
    .s_axis_b_tvalid      (b_valid),
    .s_axis_b_tready      (b_ready),
    .s_axis_b_tdata       (b_data),
    .m_axis_result_tvalid (m_valid),
    .m_axis_result_tready (m_ready),
    .m_axis_result_tdata  (m_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Output side: the head of the scoreboard must be on the bus every cycle valid is high.
  always @(negedge aclk) begin
    if (aresetn && m_valid) begin
      if (sb.size() == 0) check("unexpected_valid", {31'd0, m_valid}, 32'd0);
      else begin
        check("result", m_data, sb[0]);
        if (m_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int   n;
    logic took;
    n = 0;
    took = 1'b0;
    a_data = a; b_data = b; a_valid = 1'b1; b_valid = 1'b1;
    while (!took && n < 200) begin
      if (bp_rand) m_ready = ($urandom_range(0, 3) != 0);
      @(negedge aclk);
      took = a_ready;
      if (took) begin
        check("b_tready_pair", {31'd0, b_ready}, 32'd1);
        sb.push_back(exp);
      end
      @(posedge aclk); #1;
      n++;
    end
    check("accept", {31'd0, took}, 32'd1);
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      if (bp_rand) m_ready = ($urandom_range(0, 3) != 0);
      @(posedge aclk); #1;
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    m_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [95:0] v;
    int          n;

    a_valid = 1'b1; b_valid = 1'b1;
    a_data = 32'h3F800000; b_data = 32'h40000000;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_a_tready", {31'd0, a_ready}, 32'd0);
    check("rst_b_tready", {31'd0, b_ready}, 32'd0);
    check("rst_tvalid",   {31'd0, m_valid}, 32'd0);
    check("rst_tdata",    m_data, 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge aclk); #1 aresetn = 1'b1;
    @(posedge aclk); #1;

    send(32'h3F800000, 32'h40000000, 32'h40400000);
    check("lat_cyc1", {31'd0, m_valid}, 32'd0);
    @(posedge aclk); #1;
    check("lat_cyc2", {31'd0, m_valid}, 32'd0);
    @(posedge aclk); #1;
    check("lat_cyc3", {31'd0, m_valid}, 32'd1);
    drain();

    a_data = 32'h3F800000; a_valid = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check("lone_a_tready", {31'd0, a_ready}, 32'd0);
    end
    @(posedge aclk); #1;
    a_valid = 1'b0; b_data = 32'h3F800000; b_valid = 1'b1;
    @(negedge aclk);
    check("lone_b_tready", {31'd0, b_ready}, 32'd0);
    @(posedge aclk); #1 b_valid = 1'b0;
    repeat (4) @(posedge aclk);
    #1;

    fork
      begin
        send(32'h3F800000, 32'h3F800000, 32'h40000000);
        send(32'h40400000, 32'hC0000000, 32'h3F800000);
        send(32'h4B800001, 32'h3F800000, 32'h4B800002);
        send(32'h3FFFFFFF, 32'h33800000, 32'h40000000);
      end
      begin
        n = 0;
        while (!m_valid && n < 20) begin @(posedge aclk); #1; n++; end
        m_ready = 1'b0;
        repeat (4) @(posedge aclk);
        @(negedge aclk);
        check("bp_tready_full", {31'd0, a_ready}, 32'd0);
        check("bp_in_flight", 32'(sb.size()), 32'd3);
        @(posedge aclk); #1 m_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < NV; i++) begin
      v = VEC[i];
      send(v[95:64], v[63:32], v[31:0]);
    end
    drain();
    bp_rand = 1'b1;
    for (int i = 0; i < NV; i++) begin
      v = VEC[i];
      send(v[95:64], v[63:32], v[31:0]);
    end
    drain();
    bp_rand = 1'b0;

    m_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 32'h40000000);
    send(32'h40400000, 32'h3F800000, 32'h40800000);
    n = 0;
    while (!m_valid && n < 10) begin @(posedge aclk); #1; n++; end
    check("rst_pre_valid", {31'd0, m_valid}, 32'd1);
    aresetn = 1'b0;
    sb.delete();
    #1;
    check("rst_mid_tvalid", {31'd0, m_valid}, 32'd0);
    check("rst_mid_tdata",  m_data, 32'd0);
    m_ready = 1'b1;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    send(32'h4B800000, 32'h3F800000, 32'h4B800000);
    drain();
    repeat (6) @(posedge aclk);
    #1;

`ifdef FADD_AXIS_SUB_EN
    a_user = 1'b1;
    send(32'h40400000, 32'h3F800000, 32'h40000000);
    a_user = 1'b0;
    send(32'h40400000, 32'h3F800000, 32'h40800000);
    a_user = 1'b1;
    send(32'h3F800000, 32'h3F800000, 32'h00000000);
    a_user = 1'b0;
    drain();
`endif

    repeat (4) @(posedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
